// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the MIPS fetch stage: instruction encodings,
// fetch FSM states and the word-alignment helper.
package if_fetch_unit_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_RUN    = 2'b00,
    FS_HALTED = 2'b01,
    FS_FAULT  = 2'b10
  } fetch_state_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] addr);
    return {addr[DATA_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats capture, and an
// uncaptured cycle inserts a NOP bubble.
module if_id_reg
  import if_fetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] fetch_instr,
  input  logic [DATA_WIDTH-1:0] fetch_pc_plus4,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  valid
);

  // IF/ID contents with reset > flush > stall > capture priority
  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0000_0000;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= pc_plus4;
      valid    <= 1'b0;
    end else if (stall) begin
      instr    <= instr;
      pc_plus4 <= pc_plus4;
      valid    <= valid;
    end else if (capture) begin
      instr    <= fetch_instr;
      pc_plus4 <= fetch_pc_plus4;
      valid    <= 1'b1;
    end else begin
      instr    <= NOP_INSTR;
      pc_plus4 <= pc_plus4;
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch-stage controller: program counter, next-PC selection, HALT/fault FSM,
// and the IF/ID register feeding decode.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic [DATA_WIDTH-1:0] i_imem_instr,
  output logic [DATA_WIDTH-1:0] o_if_id_instr,
  output logic [DATA_WIDTH-1:0] o_if_id_pc_plus4,
  output logic                  o_if_id_valid,
  output logic                  o_halted,
  output logic                  o_fault
);

  localparam logic [DATA_WIDTH-1:0] FETCH_BOUND = 32'(IMEM_WORDS * 4);

  fetch_state_t          state_r, next_state_s;
  logic [DATA_WIDTH-1:0] pc_r, next_pc_s, pc_plus4_s, target_s;
  logic                  redirect_s, in_range_s, capture_s;
  logic                  halted_r, fault_r;

  assign pc_plus4_s  = pc_r + 32'h0000_0004;
  assign in_range_s  = (pc_r < FETCH_BOUND);
  assign capture_s   = (state_r == FS_RUN) && in_range_s;
  assign o_imem_addr = pc_r;
  assign o_halted    = halted_r;
  assign o_fault     = fault_r;

  // Redirect source select; the branch is older than the jump so it wins
  always_comb begin
    redirect_s = i_branch_taken | i_jump;
    if (i_branch_taken) begin
      target_s = align_word(i_branch_target);
    end else begin
      target_s = align_word(i_jump_target);
    end
  end

  // Fetch FSM next state; a redirect cancels a speculative halt or fault
  always_comb begin
    next_state_s = state_r;
    if (redirect_s) begin
      next_state_s = FS_RUN;
    end else if (i_stall) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        FS_RUN: begin
          if (!in_range_s) begin
            next_state_s = FS_FAULT;
          end else if (i_imem_instr == HALT_INSTR) begin
            next_state_s = FS_HALTED;
          end else begin
            next_state_s = FS_RUN;
          end
        end
        FS_HALTED: next_state_s = FS_HALTED;
        FS_FAULT:  next_state_s = FS_FAULT;
        default:   next_state_s = FS_FAULT;
      endcase
    end
  end

  // Next PC: the PC stops on the HALT/faulting word rather than stepping past it
  always_comb begin
    next_pc_s = pc_r;
    if (redirect_s) begin
      next_pc_s = target_s;
    end else if (i_stall) begin
      next_pc_s = pc_r;
    end else if ((state_r == FS_RUN) && (next_state_s == FS_RUN)) begin
      next_pc_s = pc_plus4_s;
    end else begin
      next_pc_s = pc_r;
    end
  end

  // PC, FSM state and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      state_r  <= FS_RUN;
      halted_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      pc_r     <= next_pc_s;
      state_r  <= next_state_s;
      halted_r <= (next_state_s == FS_HALTED);
      fault_r  <= (next_state_s == FS_FAULT);
    end
  end

  if_id_reg u_if_id_reg (
    .clk            (clk),
    .reset          (reset),
    .flush          (i_flush | redirect_s),
    .stall          (i_stall),
    .capture        (capture_s),
    .fetch_instr    (i_imem_instr),
    .fetch_pc_plus4 (pc_plus4_s),
    .instr          (o_if_id_instr),
    .pc_plus4       (o_if_id_pc_plus4),
    .valid          (o_if_id_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: behavioural fetch model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br, jmp;
  logic [31:0] br_tgt, jmp_tgt, imem_addr, imem_instr;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid, halted, fault;

  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  // model state
  bit          m_live = 1'b0;
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_halted, m_fault;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(256)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_branch_taken   (br),
    .i_branch_target  (br_tgt),
    .i_jump           (jmp),
    .i_jump_target    (jmp_tgt),
    .o_imem_addr      (imem_addr),
    .i_imem_instr     (imem_instr),
    .o_if_id_instr    (ifid_instr),
    .o_if_id_pc_plus4 (ifid_pc4),
    .o_if_id_valid    (ifid_valid),
    .o_halted         (halted),
    .o_fault          (fault)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 32'd1024) imem_instr = mem[imem_addr[9:2]];
    else imem_instr = 32'hBAD0_BAD0;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one fetch cycle
  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    end else if (m_live) begin
      logic        redir, stopped, will_stop;
      logic [31:0] tgt, w;
      redir   = br | jmp;
      tgt     = br ? br_tgt : jmp_tgt;
      tgt     = tgt & 32'hFFFF_FFFC;
      stopped = m_halted | m_fault;
      w       = word_at(m_pc);
      if (flush || redir) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
        if (!stopped && m_pc < 32'd1024) begin
          m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = 32'h0; m_valid = 1'b0;
        end
      end
      will_stop = 1'b0;
      if (redir) begin
        m_halted = 1'b0; m_fault = 1'b0; m_pc = tgt;
      end else if (!stall && !stopped) begin
        if (m_pc >= 32'd1024) begin m_fault = 1'b1; will_stop = 1'b1; end
        else if (w == 32'hFFFF_FFFF) begin m_halted = 1'b1; will_stop = 1'b1; end
        if (!will_stop) m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("model_addr", imem_addr, m_pc);
      chk("model_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("model_instr", ifid_instr, m_instr);
      if (m_valid) chk("model_pc4", ifid_pc4, m_pc4);
      chk("model_halted", {31'd0, halted}, {31'd0, m_halted});
      chk("model_fault", {31'd0, fault}, {31'd0, m_fault});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0;
    br_tgt = 32'h0; jmp_tgt = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 | 32'(i);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;

    // Reset and straight-line fetch
    do_reset();
    tick();
    chk("first_instr", ifid_instr, 32'h2008_0005);
    chk("first_pc4", ifid_pc4, 32'h4);
    chk("first_valid", {31'd0, ifid_valid}, 32'd1);
    tick();
    chk("second_instr", ifid_instr, 32'h2009_0003);
    chk("second_pc4", ifid_pc4, 32'h8);

    // Stall three cycles at PC 0x8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", imem_addr, 32'h8);
      chk("stall_instr", ifid_instr, 32'h2009_0003);
    end
    stall = 1'b0;
    tick();
    chk("resume_instr", ifid_instr, 32'h2400_0002);
    chk("resume_pc4", ifid_pc4, 32'hC);
    tick();

    // Branch + jump + stall together at PC 0x10: branch wins, one bubble
    chk("pre_redirect_pc", imem_addr, 32'h10);
    br = 1'b1; br_tgt = 32'h40; jmp = 1'b1; jmp_tgt = 32'h80; stall = 1'b1;
    tick();
    br = 1'b0; jmp = 1'b0; stall = 1'b0;
    chk("redirect_pc", imem_addr, 32'h40);
    chk("redirect_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("redirect_nop", ifid_instr, 32'h0);
    tick();
    chk("target_instr", ifid_instr, 32'h2400_0010);
    chk("target_pc4", ifid_pc4, 32'h44);

    // Plain flush squashes one capture
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
    tick();

    // HALT at 0x0C
    mem[3] = HALT_INSTR;
    do_reset();
    tick(); tick(); tick();
    tick();
    chk("halt_instr", ifid_instr, 32'hFFFF_FFFF);
    chk("halt_valid", {31'd0, ifid_valid}, 32'd1);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", imem_addr, 32'hC);
    tick(); tick();
    chk("halt_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("halt_pc_frozen", imem_addr, 32'hC);

    // Redirect cancels the halt
    br = 1'b1; br_tgt = 32'h20;
    tick();
    br = 1'b0;
    chk("unhalt", {31'd0, halted}, 32'd0);
    chk("unhalt_pc", imem_addr, 32'h20);
    tick();
    chk("unhalt_instr", ifid_instr, 32'h2400_0008);
    chk("unhalt_pc4", ifid_pc4, 32'h24);

    // Jump to last word, then run off the end of memory
    jmp = 1'b1; jmp_tgt = 32'h3FC;
    tick();
    jmp = 1'b0;
    chk("last_pc", imem_addr, 32'h3FC);
    tick();
    chk("last_instr", ifid_instr, 32'h2400_00FF);
    chk("last_pc4", ifid_pc4, 32'h400);
    chk("no_fault_yet", {31'd0, fault}, 32'd0);
    tick();
    chk("fault", {31'd0, fault}, 32'd1);
    chk("fault_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("fault_pc", imem_addr, 32'h400);
    tick();
    chk("fault_sticky", {31'd0, fault}, 32'd1);

    // Misaligned jump target clears the fault and aligns
    jmp = 1'b1; jmp_tgt = 32'h23;
    tick();
    jmp = 1'b0;
    chk("align_pc", imem_addr, 32'h20);
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    tick();
    chk("align_instr", ifid_instr, 32'h2400_0008);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-stage controller for the 5-stage MIPS pipeline.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Registers the returned instruction into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects, IF/ID flush, HALT detection and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction memory depth in words; fetch bound = IMEM_WORDS*4 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_stall  in  1  hazard unit: hold PC and IF/ID.
- i_flush  in  1  squash IF/ID contents.
- i_branch_taken  in  1  branch resolved taken (from ID/EX).
- i_branch_target  in  32  branch target byte address.
- i_jump  in  1  J/JAL/JR redirect (from ID).
- i_jump_target  in  32  jump target byte address.
- o_imem_addr  out  32  byte address to instruction memory; equals PC, combinational.
- i_imem_instr  in  32  instruction returned by instruction memory, same cycle.
- o_if_id_instr  out  32  registered instruction.
- o_if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- o_if_id_valid  out  1  IF/ID holds a real instruction.
- o_halted  out  1  fetch stopped on HALT.
- o_fault  out  1  sticky: fetch attempted at PC >= IMEM_WORDS*4.

Behaviour:
- Reset (synchronous, active-high):
  - PC = RESET_PC; state = RUN.
  - o_if_id_instr = NOP (32'h0); o_if_id_pc_plus4 = 0; o_if_id_valid = 0.
  - o_halted = 0; o_fault = 0.
- FSM states and transitions:
  - RUN -> HALTED when i_imem_instr == HALT_INSTR and the fetch is accepted (no stall, no redirect).
  - RUN -> FAULT when PC >= IMEM_WORDS*4 and the fetch is accepted; the faulting word is not captured.
  - HALTED/FAULT -> RUN on any redirect, because the halt or fault was speculative behind an older branch; o_halted and o_fault clear.
  - Outside of a redirect, HALTED and FAULT are exited only by reset.
- Redirect:
  - redirect = i_branch_taken | i_jump; the target is i_branch_target if i_branch_taken, else i_jump_target.
  - When both are asserted, the branch wins because it comes from the older instruction.
  - Bits [1:0] of the target are forced to 00.
- Next-PC priority: reset > redirect > stall (hold) > HALTED/FAULT (hold) > PC+4.
  - Redirect overrides stall.
  - PC+4 wraps mod 2^32.
- IF/ID priority: reset > (i_flush | redirect) > stall > capture.
  - flush/redirect: instr = NOP, valid = 0.
  - stall: all fields hold.
  - capture in RUN, in-range PC: instr = i_imem_instr, pc_plus4 = PC+4, valid = 1. A captured HALT_INSTR is passed downstream with valid = 1.
  - capture in HALTED/FAULT: NOP bubble, valid = 0.
- Latency: an instruction at PC appears on o_if_id_* one clock after PC is presented. A redirect presents the target PC on the next cycle, so exactly one bubble.
- o_halted = (state == HALTED). o_fault = (state == FAULT). Both are registered.

Decomposition:
- Add to mips_pkg.vh:
  - HALT_INSTR = 32'hFFFF_FFFF.
  - NOP_INSTR = 32'h0000_0000.
  - Fetch state encodings FS_RUN, FS_HALTED, FS_FAULT.
  - Existing DATA_WIDTH.
- One natural sub-module: if_id_reg, the IF/ID register with stall/flush priority.
- PC, next-PC mux and FSM remain in if_fetch_unit.

Test Plan:
- Reset behaviour: reset for 2 cycles, memory holding words 0x20080005, 0x20090003, ... -> o_imem_addr = 0x0 during reset; after release, o_if_id_instr = 0x20080005 with pc_plus4 = 0x4 and valid = 1, then 0x20090003 with pc_plus4 = 0x8.
- Stall: i_stall high for 3 cycles at PC 0x8 -> PC stays 0x8 and IF/ID holds the 0x4 instruction unchanged; fetch resumes at 0x8 on release.
- Simultaneous redirects: i_branch_taken = 1 (target 0x40), i_jump = 1 (target 0x80) and i_stall = 1 in the same cycle at PC 0x10 -> next PC = 0x40; IF/ID = NOP with valid = 0; following cycle captures word 0x40 with pc_plus4 = 0x44.
- HALT capture: HALT_INSTR at 0x0C -> IF/ID captures 0xFFFFFFFF with valid = 1; o_halted = 1; PC frozen at 0x0C; subsequent IF/ID cycles are NOP with valid = 0.
- Halt cancelled by redirect: while HALTED, i_branch_taken = 1 with target 0x20 -> o_halted = 0; PC = 0x20; fetch resumes.
- Out-of-range fetch and misaligned target: jump to 0x3FC with IMEM_WORDS = 256 -> word 0x3FC captured, next PC 0x400 -> o_fault = 1, valid = 0 thereafter. Separately, jump target 0x23 -> PC = 0x20.
